// File: rtl/pipe_fetch_queue_if.sv
// Bundle between the fetch queue, the instruction memory, the hazard unit and ID.
// The master side is the fetch queue itself; the slave side is its environment.
interface pipe_fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          imem_req;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_rdata;
    logic          stall;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          out_valid;
    logic [31:0]   out_inst;
    logic [31:0]   out_pc4;
    logic [CW-1:0] count;

    modport master (
        output imem_req, imem_addr, out_valid, out_inst, out_pc4, count,
        input  imem_rdata, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_inst, out_pc4, count,
        output imem_rdata, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/pipe_fetch_queue.sv
// Instruction prefetch queue: sequential fetch from a 1-cycle synchronous memory,
// first-word fall-through FIFO of {inst, pc}, stall hold and redirect flush.
module pipe_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clock,
    input  logic            reset,
    pipe_fetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   inst_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];

    logic [CW:0]   occ_s;
    logic          valid_s;
    logic          issue_s;
    logic          push_s;
    logic          pop_s;
    logic [1:0]    unused_pc_lsb_s;

    assign unused_pc_lsb_s = bus.redirect_pc[1:0];

    // Handshake decode; every slot held or in flight counts against DEPTH, so no push can overflow
    always_comb begin
        occ_s   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        valid_s = (count_q != {CW{1'b0}});
        issue_s = ~reset & ~bus.redirect & (occ_s < DEPTH_L);
        push_s  = inflight_q & ~bus.redirect;
        pop_s   = valid_s & ~bus.stall & ~bus.redirect;
    end

    // Next-state: redirect flushes everything and retargets fetch
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = 1'b0;
        req_pc_d   = req_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (bus.redirect) begin
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            head_d     = {PW{1'b0}};
            tail_d     = {PW{1'b0}};
            count_d    = {CW{1'b0}};
        end else begin
            inflight_d = issue_s;
            if (issue_s) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                req_pc_d   = fetch_pc_q;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (push_s) begin
                tail_d = tail_q + PW'(1);
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = head_q + PW'(1);
            end else begin
                head_d = head_q;
            end
            count_d = count_q + CW'(push_s) - CW'(pop_s);
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            req_pc_q   <= RESET_PC;
            head_q     <= {PW{1'b0}};
            tail_q     <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            req_pc_q   <= req_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; contents need no reset because count gates visibility
    always_ff @(posedge clock) begin
        if (push_s && !reset) begin
            inst_q[tail_q] <= bus.imem_rdata;
            pc_q[tail_q]   <= req_pc_q;
        end
    end

    assign bus.imem_req  = issue_s;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.out_valid = valid_s;
    assign bus.out_inst  = inst_q[head_q];
    assign bus.out_pc4   = pc_q[head_q] + 32'd4;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_pipe_fetch_queue.sv
// Directed bench for pipe_fetch_queue: a memory model returns addr^K, and a
// scoreboard of expected PCs is checked against every pop the queue makes.
module tb_pipe_fetch_queue;
    localparam logic [31:0] K = 32'hA5A5_0000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pipe_fetch_queue_if #(.DEPTH(4)) bus ();
    pipe_fetch_queue_if #(.DEPTH(4)) bus_w ();

    pipe_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    pipe_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clock (clock),
        .reset (reset),
        .bus   (bus_w.master)
    );

    // Synchronous memory models: word valid one cycle after the request
    always @(posedge clock) begin
        bus.imem_rdata   <= bus.imem_req   ? (bus.imem_addr   ^ K) : 32'hDEAD_BEEF;
        bus_w.imem_rdata <= bus_w.imem_req ? (bus_w.imem_addr ^ K) : 32'hDEAD_BEEF;
    end

    int total = 0;
    int bad   = 0;
    int pops  = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mon_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_exp(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 48; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic step(input logic rst, input logic st, input logic rd, input logic [31:0] rpc);
        @(posedge clock);
        #1;
        reset           = rst;
        bus.stall       = st;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        @(negedge clock);
    endtask

    // Scoreboard: every pop must match the next expected PC in order
    always @(negedge clock) begin
        if (!reset && bus.out_valid && !bus.stall && !bus.redirect) begin
            pops++;
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL pop_unexpected observed=pop pc4=%h expected=no pop", bus.out_pc4);
            end
            if (exp_q.size() != 0) begin
                mon_pc = exp_q.pop_front();
                chk("pop_pc4", bus.out_pc4, mon_pc + 32'd4);
                chk("pop_inst", bus.out_inst, mon_pc ^ K);
            end
        end
    end

    initial begin
        bus.stall         = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_pc   = 32'h0;
        bus_w.stall       = 1'b0;
        bus_w.redirect    = 1'b0;
        bus_w.redirect_pc = 32'h0;

        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("rst_req",   32'(bus.imem_req),  32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_count", 32'(bus.count),     32'd0);
        load_exp(32'h0);

        // Free run, cycles 0..7
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("c0_req",   32'(bus.imem_req),  32'd1);
        chk("c0_addr",  bus.imem_addr,      32'h0);
        chk("c0_valid", 32'(bus.out_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("c1_addr",  bus.imem_addr,      32'h4);
        chk("c1_valid", 32'(bus.out_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("c2_valid", 32'(bus.out_valid), 32'd1);
        chk("c2_pc4",   bus.out_pc4,        32'h4);
        chk("wrap_pc4_0", bus_w.out_pc4,    32'hFFFF_FFFC);
        chk("wrap_inst_0", bus_w.out_inst,  32'hFFFF_FFF8 ^ K);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("wrap_pc4_1", bus_w.out_pc4,    32'h0000_0000);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("wrap_pc4_2", bus_w.out_pc4,    32'h0000_0004);
        chk("wrap_inst_2", bus_w.out_inst,  32'h0000_0000 ^ K);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            chk("run_req", 32'(bus.imem_req), 32'd1);
        end

        // Stall cycles 8..17: head (pc 24) frozen, queue fills to 4
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            chk("stall_head_pc4", bus.out_pc4, 32'd28);
            if (i >= 3) begin
                chk("stall_count", 32'(bus.count),    32'd4);
                chk("stall_req",   32'(bus.imem_req), 32'd0);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            chk("release_valid", 32'(bus.out_valid), 32'd1);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);

        // Redirect to 0x103
        step(1'b0, 1'b0, 1'b1, 32'h0000_0103);
        chk("redir_req", 32'(bus.imem_req), 32'd0);
        load_exp(32'h100);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("redir1_valid", 32'(bus.out_valid), 32'd0);
        chk("redir1_count", 32'(bus.count),     32'd0);
        chk("redir1_req",   32'(bus.imem_req),  32'd1);
        chk("redir1_addr",  bus.imem_addr,      32'h100);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("redir2_valid", 32'(bus.out_valid), 32'd0);
        chk("redir2_addr",  bus.imem_addr,      32'h104);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("redir3_valid", 32'(bus.out_valid), 32'd1);
        chk("redir3_pc4",   bus.out_pc4,        32'h104);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);

        // Fill, then redirect together with stall
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("fill_count", 32'(bus.count), 32'd4);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0200);
        chk("rs_req", 32'(bus.imem_req), 32'd0);
        load_exp(32'h200);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rs_count", 32'(bus.count),     32'd0);
        chk("rs_valid", 32'(bus.out_valid), 32'd0);
        chk("rs_addr",  bus.imem_addr,      32'h200);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rs_pc4", bus.out_pc4, 32'h204);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0);

        // Reset while count=3 with a word in flight
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("mid_count", 32'(bus.count), 32'd3);
        chk("mid_req",   32'(bus.imem_req), 32'd0);
        load_exp(32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("post_count", 32'(bus.count),     32'd0);
        chk("post_valid", 32'(bus.out_valid), 32'd0);
        chk("post_req",   32'(bus.imem_req),  32'd1);
        chk("post_addr",  bus.imem_addr,      32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("post1_valid", 32'(bus.out_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("post2_pc4", bus.out_pc4, 32'h4);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0);

        chk("pops_seen", 32'(pops > 20), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
